// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus bundle: IF/ID input side, writeback port and ID/EX output side.
interface decode_stage_pipe_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned CTRL_W = 24
);
  // IF/ID side
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_ir;
  logic [XLEN-1:0]   in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_ext_op;
  logic              in_uses_rs;
  logic              in_uses_rt;
  logic              in_is_load;
  logic [AW-1:0]     in_dst;
  logic              flush;

  // Writeback port
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;

  // ID/EX side
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_busA;
  logic [XLEN-1:0]   out_busB;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_shamt;
  logic [AW-1:0]     out_rs;
  logic [AW-1:0]     out_rt;
  logic [AW-1:0]     out_dst;
  logic [XLEN-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_is_load;

  // Upstream/downstream environment view
  modport master (
    output in_valid, in_ir, in_pc, in_ctrl, in_ext_op, in_uses_rs, in_uses_rt,
           in_is_load, in_dst, flush, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_busA, out_busB, out_imm, out_shamt, out_rs,
           out_rt, out_dst, out_pc, out_ctrl, out_is_load
  );

  // Decode stage view
  modport slave (
    input  in_valid, in_ir, in_pc, in_ctrl, in_ext_op, in_uses_rs, in_uses_rt,
           in_is_load, in_dst, flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_busA, out_busB, out_imm, out_shamt, out_rs,
           out_rt, out_dst, out_pc, out_ctrl, out_is_load
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Decode stage: 2R/1W register file with WB->ID bypass, field extract and immediate
// extension, load-use interlock, and an ID/EX register with valid/ready and flush.
module decode_stage_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CTRL_W   = 24,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic                clk,
  input logic                reset,
  decode_stage_pipe_if.slave bus
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  // Register file storage
  logic [XLEN-1:0] regs_q [NUM_REGS];

  // Field extraction; indices take the low AW bits of each 5-bit field
  logic [AW-1:0]   rs_idx;
  logic [AW-1:0]   rt_idx;
  logic [15:0]     imm16;
  logic [4:0]      shamt5;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] shamt_ext;
  logic            unused_ir_bits;

  assign rs_idx         = bus.in_ir[21 +: AW];
  assign rt_idx         = bus.in_ir[16 +: AW];
  assign imm16          = bus.in_ir[15:0];
  assign shamt5         = bus.in_ir[10:6];
  assign unused_ir_bits = ^bus.in_ir[31:26];

  // Immediate and shift-amount extension
  always_comb begin
    imm_ext   = bus.in_ext_op ? {{(XLEN-16){imm16[15]}}, imm16} : {{(XLEN-16){1'b0}}, imm16};
    shamt_ext = {{(XLEN-5){1'b0}}, shamt5};
  end

  // Write is suppressed for r0 when it is hardwired to zero
  logic wr_en;
  assign wr_en = bus.wb_en && !(ZERO_REG && (bus.wb_addr == '0));

  // Register file write port, cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Combinational read ports with same-cycle writeback bypass; r0 forced to 0 if hardwired
  logic [XLEN-1:0] rdata_a;
  logic [XLEN-1:0] rdata_b;

  always_comb begin
    rdata_a = regs_q[rs_idx];
    rdata_b = regs_q[rt_idx];
    if (wr_en && (bus.wb_addr == rs_idx)) rdata_a = bus.wb_data;
    if (wr_en && (bus.wb_addr == rt_idx)) rdata_b = bus.wb_data;
    if (ZERO_REG && (rs_idx == '0)) rdata_a = '0;
    if (ZERO_REG && (rt_idx == '0)) rdata_b = '0;
  end

  // ID/EX pipeline register
  logic              out_valid_q,   out_valid_d;
  logic [XLEN-1:0]   out_busa_q,    out_busa_d;
  logic [XLEN-1:0]   out_busb_q,    out_busb_d;
  logic [XLEN-1:0]   out_imm_q,     out_imm_d;
  logic [XLEN-1:0]   out_shamt_q,   out_shamt_d;
  logic [AW-1:0]     out_rs_q,      out_rs_d;
  logic [AW-1:0]     out_rt_q,      out_rt_d;
  logic [AW-1:0]     out_dst_q,     out_dst_d;
  logic [XLEN-1:0]   out_pc_q,      out_pc_d;
  logic [CTRL_W-1:0] out_ctrl_q,    out_ctrl_d;
  logic              out_is_load_q, out_is_load_d;

  // Load-use interlock against the instruction currently held in ID/EX
  logic hazard;
  logic advance;
  logic capture;

  always_comb begin
    hazard  = bus.in_valid && out_valid_q && out_is_load_q && (out_dst_q != '0) &&
              ((bus.in_uses_rs && (rs_idx == out_dst_q)) ||
               (bus.in_uses_rt && (rt_idx == out_dst_q)));
    advance = !out_valid_q || bus.out_ready;
    capture = advance && bus.in_valid && !hazard && !bus.flush;
  end

  assign bus.in_ready = advance && !hazard && !bus.flush;

  // Next-state: flush > capture > bubble > hold
  always_comb begin
    out_valid_d   = out_valid_q;
    out_busa_d    = out_busa_q;
    out_busb_d    = out_busb_q;
    out_imm_d     = out_imm_q;
    out_shamt_d   = out_shamt_q;
    out_rs_d      = out_rs_q;
    out_rt_d      = out_rt_q;
    out_dst_d     = out_dst_q;
    out_pc_d      = out_pc_q;
    out_ctrl_d    = out_ctrl_q;
    out_is_load_d = out_is_load_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d   = 1'b1;
      out_busa_d    = rdata_a;
      out_busb_d    = rdata_b;
      out_imm_d     = imm_ext;
      out_shamt_d   = shamt_ext;
      out_rs_d      = rs_idx;
      out_rt_d      = rt_idx;
      out_dst_d     = bus.in_dst;
      out_pc_d      = bus.in_pc;
      out_ctrl_d    = bus.in_ctrl;
      out_is_load_d = bus.in_is_load;
    end else if (advance) begin
      out_valid_d = 1'b0;
    end
  end

  // ID/EX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_busa_q    <= '0;
      out_busb_q    <= '0;
      out_imm_q     <= '0;
      out_shamt_q   <= '0;
      out_rs_q      <= '0;
      out_rt_q      <= '0;
      out_dst_q     <= '0;
      out_pc_q      <= '0;
      out_ctrl_q    <= '0;
      out_is_load_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_busa_q    <= out_busa_d;
      out_busb_q    <= out_busb_d;
      out_imm_q     <= out_imm_d;
      out_shamt_q   <= out_shamt_d;
      out_rs_q      <= out_rs_d;
      out_rt_q      <= out_rt_d;
      out_dst_q     <= out_dst_d;
      out_pc_q      <= out_pc_d;
      out_ctrl_q    <= out_ctrl_d;
      out_is_load_q <= out_is_load_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_busA    = out_busa_q;
  assign bus.out_busB    = out_busb_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_shamt   = out_shamt_q;
  assign bus.out_rs      = out_rs_q;
  assign bus.out_rt      = out_rt_q;
  assign bus.out_dst     = out_dst_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_ctrl    = out_ctrl_q;
  assign bus.out_is_load = out_is_load_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe.
module tb_decode_stage_pipe;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   xfers;

  decode_stage_pipe_if #(.XLEN(32), .AW(5), .CTRL_W(24)) dut_if ();

  decode_stage_pipe #(
    .XLEN     (32),
    .NUM_REGS (32),
    .CTRL_W   (24),
    .ZERO_REG (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ID/EX handshakes
  always @(posedge clk) begin
    if (dut_if.out_valid && dut_if.out_ready) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                       input logic urs, input logic urt, input logic ld,
                       input logic [4:0] dst, input logic [31:0] pc);
    dut_if.in_valid   = 1'b1;
    dut_if.in_ir      = {6'd0, rs, rt, imm};
    dut_if.in_uses_rs = urs;
    dut_if.in_uses_rt = urt;
    dut_if.in_is_load = ld;
    dut_if.in_dst     = dst;
    dut_if.in_pc      = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    dut_if.wb_en   = en;
    dut_if.wb_addr = a;
    dut_if.wb_data = d;
  endtask

  int x0;

  initial begin
    checks = 0;
    errors = 0;
    xfers  = 0;
    reset  = 1'b0;
    dut_if.in_valid   = 1'b0;
    dut_if.in_ir      = '0;
    dut_if.in_pc      = '0;
    dut_if.in_ctrl    = '0;
    dut_if.in_ext_op  = 1'b0;
    dut_if.in_uses_rs = 1'b0;
    dut_if.in_uses_rt = 1'b0;
    dut_if.in_is_load = 1'b0;
    dut_if.in_dst     = '0;
    dut_if.flush      = 1'b0;
    dut_if.out_ready  = 1'b1;
    wb(1'b0, 5'd0, 32'd0);

    // Reset state
    #1;
    chk("rst_valid", 32'(dut_if.out_valid), 32'd0);
    chk("rst_busA", dut_if.out_busA, 32'd0);
    chk("rst_pc", dut_if.out_pc, 32'd0);
    #11 reset = 1'b1;

    // 1. Read r5 after reset, then write and read back
    instr(5'd5, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd1, 32'h10);
    dut_if.in_ctrl = 24'hA5A5A5;
    step();
    chk("t1_valid", 32'(dut_if.out_valid), 32'd1);
    chk("t1_busA_rst", dut_if.out_busA, 32'd0);
    chk("t1_rs", 32'(dut_if.out_rs), 32'd5);
    chk("t1_ctrl", 32'(dut_if.out_ctrl), 32'h00A5A5A5);
    chk("t1_pc", dut_if.out_pc, 32'h10);
    dut_if.in_valid = 1'b0;
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk("t1_bubble", 32'(dut_if.out_valid), 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    instr(5'd5, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd1, 32'h14);
    step();
    chk("t1_busA_wr", dut_if.out_busA, 32'hDEADBEEF);

    // 2. Same-cycle bypass on rt
    instr(5'd0, 5'd7, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 32'h18);
    wb(1'b1, 5'd7, 32'h00001234);
    #1 chk("t2_in_ready", 32'(dut_if.in_ready), 32'd1);
    step();
    chk("t2_busB_byp", dut_if.out_busB, 32'h00001234);
    chk("t2_rt", 32'(dut_if.out_rt), 32'd7);

    // 3. r0 stays zero: bypass suppressed, write ignored
    instr(5'd0, 5'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 5'd2, 32'h1C);
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    chk("t3_byp_A", dut_if.out_busA, 32'd0);
    chk("t3_byp_B", dut_if.out_busB, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    step();
    chk("t3_rd_A", dut_if.out_busA, 32'd0);

    // 4. Load to r3 followed by dependent add: one bubble
    instr(5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd3, 32'h20);
    step();
    chk("t4_ld_valid", 32'(dut_if.out_valid), 32'd1);
    chk("t4_ld_dst", 32'(dut_if.out_dst), 32'd3);
    instr(5'd3, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd4, 32'h24);
    wb(1'b1, 5'd3, 32'hCAFE0003);
    #1 chk("t4_stall_rdy", 32'(dut_if.in_ready), 32'd0);
    step();
    chk("t4_bubble", 32'(dut_if.out_valid), 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    #1 chk("t4_rdy_again", 32'(dut_if.in_ready), 32'd1);
    step();
    chk("t4_add_valid", 32'(dut_if.out_valid), 32'd1);
    chk("t4_add_busA", dut_if.out_busA, 32'hCAFE0003);
    chk("t4_add_pc", dut_if.out_pc, 32'h24);

    // 5. EX back-pressure for 3 cycles, then release
    dut_if.out_ready = 1'b0;
    instr(5'd5, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd9, 32'h200);
    x0 = xfers;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_stall_rdy", 32'(dut_if.in_ready), 32'd0);
      step();
      chk("t5_hold_pc", dut_if.out_pc, 32'h24);
      chk("t5_hold_valid", 32'(dut_if.out_valid), 32'd1);
    end
    dut_if.out_ready = 1'b1;
    #1 chk("t5_rel_rdy", 32'(dut_if.in_ready), 32'd1);
    step();
    chk("t5_xfer_once", 32'(xfers - x0), 32'd1);
    chk("t5_new_pc", dut_if.out_pc, 32'h200);
    chk("t5_new_busA", dut_if.out_busA, 32'hDEADBEEF);
    dut_if.in_valid = 1'b0;
    step();
    chk("t5_drain", 32'(dut_if.out_valid), 32'd0);

    // 6. Immediate and shamt extension
    instr(5'd0, 5'd0, 16'h8000, 1'b0, 1'b0, 1'b0, 5'd1, 32'h30);
    dut_if.in_ext_op = 1'b1;
    step();
    chk("t6_sext", dut_if.out_imm, 32'hFFFF8000);
    dut_if.in_ext_op = 1'b0;
    step();
    chk("t6_zext", dut_if.out_imm, 32'h00008000);
    instr(5'd0, 5'd0, 16'h07C0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h34);
    step();
    chk("t6_shamt", dut_if.out_shamt, 32'd31);

    // Flush with a valid instruction held
    dut_if.flush = 1'b1;
    #1 chk("fl_rdy", 32'(dut_if.in_ready), 32'd0);
    step();
    chk("fl_valid", 32'(dut_if.out_valid), 32'd0);
    dut_if.flush = 1'b0;

    // Flush during a load-use hazard
    instr(5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd6, 32'h40);
    step();
    instr(5'd6, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd7, 32'h44);
    dut_if.flush = 1'b1;
    step();
    chk("fl_hz_valid", 32'(dut_if.out_valid), 32'd0);
    dut_if.flush = 1'b0;

    // Reset mid-operation empties the pipe and clears the regfile
    instr(5'd5, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd1, 32'h50);
    step();
    chk("mr_pre_valid", 32'(dut_if.out_valid), 32'd1);
    #2 reset = 1'b0;
    #1 chk("mr_valid", 32'(dut_if.out_valid), 32'd0);
    chk("mr_busA", dut_if.out_busA, 32'd0);
    #2 reset = 1'b1;
    step();
    chk("mr_r5_clear", dut_if.out_busA, 32'd0);
    chk("mr_after_valid", 32'(dut_if.out_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
